systolic_array_nxn: RTL
=======================

Name: systolic_array_nxn

Overview:
Parametrised N x N weight-stationary systolic matrix-vector engine, successor to the fixed 2x2 array. Computes y[j] = sum over i of x[i]*W[i][j]: x[i] flows right along row i, partial sums flow down column j. Adds an internal controller FSM, row-serial weight loading, a valid/ready input stream, internal input skew and output deskew, and a done pulse. Sits between the vector feeder and the result writeback.

Parameters:
N, 4, array dimension (rows = columns = lanes), N >= 2
DATA_WIDTH, 8, unsigned width of x and W elements
ACC_WIDTH, 20, unsigned partial-sum/output width, >= 2*DATA_WIDTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
w_valid  in  1  write one weight row this cycle
w_row  in  clog2(N)  row index i being written
w_data  in  N*DATA_WIDTH  lane j = W[w_row][j] at bits [j*DATA_WIDTH +: DATA_WIDTH]
start  in  1  begin a streaming job
x_valid  in  1  input vector valid
x_ready  out  1  engine accepts a vector
x_last  in  1  qualifies the final vector of the job
x_data  in  N*DATA_WIDTH  lane i = x[i]
y_valid  out  1  result vector valid, single cycle per vector
y_data  out  N*ACC_WIDTH  lane j = y[j]
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset (reset=0, asynchronous): all weights, pipeline registers, skew/deskew registers cleared to 0; x_ready=0, y_valid=0, y_data=0, busy=0, done=0; FSM -> IDLE. Reset mid-job abandons it with no done pulse.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE: x_ready=0. A w_valid edge writes row w_row. start=1 -> STREAM. If w_valid and start coincide, the write completes and all vectors of the job use the new row. w_row >= N is ignored.
- STREAM: x_ready=1. A vector is accepted on any edge with x_valid=1. x_valid=0 inserts a bubble, which produces no y_valid. Accepting with x_last=1 -> DRAIN. w_valid and start are ignored.
- DRAIN: x_ready=0. A counter runs for 2*N cycles. On the final count, done=1 for exactly one cycle, then -> IDLE. w_valid and start are ignored.
- Dataflow: row i input is delayed i cycles (skew). Each PE registers x rightward and psum_out = psum_in + x*W[i][j] downward, with psum_in = 0 for row 0. Column j output is delayed N-1-j cycles (deskew) and then registered.
- Latency: a vector accepted on edge E appears on y_data with y_valid=1 after edge E+2*N. Back-to-back vectors produce back-to-back results: throughput is 1 vector/cycle.
- A valid bit travels with each vector through the skew pipeline. y_data holds its last value when y_valid=0.
- Arithmetic: unsigned. Products are 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH. Sums wrap modulo 2^ACC_WIDTH unless the option below is enabled.
- done is asserted the cycle after the final y_valid, or later. It never precedes a result of the job.
- A job whose first accepted vector carries x_last=1 is legal and yields exactly one result.

Optional Feature:
- SYSTOLIC_SATURATE_EN defined: every PE add clamps to 2^ACC_WIDTH-1 on overflow. Saturation is sticky down the column, so the output is the clamped max.
- Undefined: plain modulo-2^ACC_WIDTH wrap.

Test Plan:
- N=2, W rows [1,2],[3,4], start, one vector x=[5,6] with x_last -> y_valid after edge E+4, y_data=[23,34]; done pulses once afterwards; busy falls.
- N=4, W=identity, stream x=[1,2,3,4],[5,6,7,8],[9,10,11,12] back-to-back -> three consecutive y_valid cycles starting 8 cycles after the first accept, y equal to x.
- N=4, W=identity, vectors with x_valid toggling 1,0,1 -> exactly two y_valid pulses separated by one idle cycle, and bubbles generate no results.
- N=4, ACC_WIDTH=16, all x=255 and all W=255 -> y lanes = 65535 with SYSTOLIC_SATURATE_EN, 63492 without.
- Reset driven to 0 during STREAM after 2 accepts -> outputs immediately 0, no y_valid or done follows. After release, reloading weights and a new job gives correct results, and any unreloaded rows read 0.
- w_valid during STREAM with w_row=0, data all 9 -> ignored; results still reflect the original weights. w_valid together with start in IDLE -> new row used.

Source files
------------

// File: rtl/systolic_array_nxn.sv
// systolic_array_nxn: N x N weight-stationary systolic matrix-vector engine.
// Define SYSTOLIC_SATURATE_EN for saturating partial sums (default: wrap).
module systolic_array_nxn #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w_valid,
  input  logic [$clog2(N)-1:0]    w_row,
  input  logic [N*DATA_WIDTH-1:0] w_data,
  input  logic                    start,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic                    x_last,
  input  logic [N*DATA_WIDTH-1:0] x_data,
  output logic                    y_valid,
  output logic [N*ACC_WIDTH-1:0]  y_data,
  output logic                    busy,
  output logic                    done
);
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(2*N+1);
  localparam int PW = 2*DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   x_ready_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   y_valid_q;
  logic [N*ACC_WIDTH-1:0] y_q;
  logic [2*N-1:0]         vld_q;
  logic                   acc;

  logic [DATA_WIDTH-1:0] w_q  [N][N];
  logic [DATA_WIDTH-1:0] sk_q [N][N];
  logic [DATA_WIDTH-1:0] xr_q [N][N-1];
  logic [DATA_WIDTH-1:0] xin  [N][N];
  logic [ACC_WIDTH-1:0]  pin  [N][N];
  logic [ACC_WIDTH-1:0]  ps_q [N][N];
  logic [ACC_WIDTH-1:0]  ps_d [N][N];
  logic [ACC_WIDTH-1:0]  ds_q [N][N-1];
  logic [ACC_WIDTH-1:0]  col  [N];

  assign acc     = x_ready_q & x_valid;
  assign x_ready = x_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign y_valid = y_valid_q;
  assign y_data  = y_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      x_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_STREAM;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_STREAM: begin
          if (x_valid && x_last) begin
            state_q   <= S_DRAIN;
            x_ready_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        S_DRAIN: begin
          // one spare count so done trails the last result
          if (cnt_q == CW'(2*N)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w_q[i][j] <= '0;
    end else if (w_valid && state_q == S_IDLE) begin
      for (int i = 0; i < N; i++)
        if (w_row == RW'(i))
          for (int j = 0; j < N; j++)
            w_q[i][j] <= w_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      xin[i][0] = sk_q[i][i];
      for (int j = 1; j < N; j++)
        xin[i][j] = xr_q[i][j-1];
    end
    for (int j = 0; j < N; j++)
      pin[0][j] = '0;
    for (int i = 1; i < N; i++)
      for (int j = 0; j < N; j++)
        pin[i][j] = ps_q[i-1][j];
    for (int j = 0; j < N-1; j++)
      col[j] = ds_q[j][N-2-j];
    col[N-1] = ps_q[N-1][N-1];
  end

  always_comb begin : pe_math
    logic [PW-1:0] p;
`ifdef SYSTOLIC_SATURATE_EN
    logic [ACC_WIDTH:0] s;
    s = '0;
`endif
    p = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        p = PW'(w_q[i][j]) * PW'(xin[i][j]);
`ifdef SYSTOLIC_SATURATE_EN
        s = {1'b0, pin[i][j]} + (ACC_WIDTH+1)'(p);
        ps_d[i][j] = s[ACC_WIDTH] ? '1 : s[ACC_WIDTH-1:0];
`else
        ps_d[i][j] = pin[i][j] + ACC_WIDTH'(p);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q     <= '0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          sk_q[i][j] <= '0;
          ps_q[i][j] <= '0;
        end
        for (int j = 0; j < N-1; j++) begin
          xr_q[i][j] <= '0;
          ds_q[i][j] <= '0;
        end
      end
    end else begin
      vld_q     <= {vld_q[2*N-2:0], acc};
      y_valid_q <= vld_q[2*N-1];
      if (vld_q[2*N-1])
        for (int j = 0; j < N; j++)
          y_q[j*ACC_WIDTH +: ACC_WIDTH] <= col[j];
      for (int i = 0; i < N; i++) begin
        sk_q[i][0] <= acc ? x_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= i; k++)
          sk_q[i][k] <= sk_q[i][k-1];
        for (int j = 0; j < N-1; j++)
          xr_q[i][j] <= xin[i][j];
        for (int j = 0; j < N; j++)
          ps_q[i][j] <= ps_d[i][j];
      end
      // column j waits N-1-j cycles so all lanes land together
      for (int j = 0; j < N-1; j++) begin
        ds_q[j][0] <= ps_q[N-1][j];
        for (int k = 1; k < N-1-j; k++)
          ds_q[j][k] <= ds_q[j][k-1];
      end
    end
  end

endmodule
